// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: handshake stage state and occupancy decode.
package pipe_pkg;

  localparam int unsigned OCC_W = 2;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_FULL  = 2'd2
  } pipestate_t;

  // Number of payloads held in each state.
  function automatic logic [OCC_W-1:0] occ_of(input pipestate_t s);
    case (s)
      PS_ONE:  return OCC_W'(1);
      PS_FULL: return OCC_W'(2);
      default: return OCC_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter: holds at all-ones, cleared only by synchronous reset.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer,
// flush-to-NOP and saturating stall/flush counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned     WIDTH = 32,
  parameter logic [WIDTH-1:0] NOP  = '0,
  parameter int unsigned     CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  pipestate_t       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire;
  logic             out_fire;
  logic             stall_inc;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= PS_EMPTY;
      main_q  <= NOP;
      skid_q  <= NOP;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // in_ready looks only at registered state, flush and reset; never out_ready.
  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    skid_d    = skid_q;
    in_ready  = !RST && !flush && (state_q != PS_FULL);
    out_valid = (state_q != PS_EMPTY);
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    stall_inc = out_valid && !out_ready;

    if (flush) begin
      state_d = PS_EMPTY;
      main_d  = NOP;
      skid_d  = NOP;
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = PS_ONE;
          end
        end
        PS_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = PS_FULL;
          end else if (out_fire) begin
            main_d  = NOP;
            state_d = PS_EMPTY;
          end
        end
        PS_FULL: begin
          // Skid entry is older than anything upstream, so it moves up first.
          if (out_fire) begin
            main_d  = skid_q;
            skid_d  = NOP;
            state_d = PS_ONE;
          end
        end
        default: begin
          state_d = PS_EMPTY;
          main_d  = NOP;
          skid_d  = NOP;
        end
      endcase
    end
  end

  assign out_data  = main_q;
  assign occupancy = occ_of(state_q);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (flush),
    .count (flush_cnt)
  );

endmodule
